// File: rtl/rs_stream_encoder.sv
// Systematic Reed-Solomon encoder over GF(16) (x^4+x+1) with valid/ready streams.
// Emits K message symbols followed by PARITY check symbols, highest degree first.
module rs_stream_encoder #(
  parameter int unsigned K      = 9,
  parameter int unsigned PARITY = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_sym,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sym,
  output logic       out_first,
  output logic       out_last,
  output logic       busy
);

  localparam int unsigned SYM_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned GEN_W = 64;

  if (K < 1 || K > 13 || PARITY < 2 || PARITY > 15 - K || (PARITY % 2) != 0) begin : g_bad_params
    $error("rs_stream_encoder: illegal K=%0d PARITY=%0d", K, PARITY);
  end

  // GF(16) multiply: shift-and-add with x^4 folded back as x+1.
  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                               input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  // Generator g(x) = prod_{i=1..np} (x + alpha^i); coefficient j at bits [4j+:4].
  function automatic logic [GEN_W-1:0] gen_poly(input int np);
    logic [GEN_W-1:0] g;
    logic [SYM_W-1:0] root;
    g      = '0;
    g[3:0] = 4'h1;
    root   = 4'h1;
    for (int i = 1; i <= 15; i++) begin
      if (i <= np) begin
        root = gf_mul(root, 4'h2);
        for (int j = 15; j >= 1; j--) begin
          g[4*j +: 4] = g[4*(j-1) +: 4] ^ gf_mul(root, g[4*j +: 4]);
        end
        g[3:0] = gf_mul(root, g[3:0]);
      end
    end
    return g;
  endfunction

  localparam logic [GEN_W-1:0] GEN = gen_poly(int'(PARITY));

  typedef enum logic {ST_MSG, ST_PAR} state_t;

  state_t                       state_q, state_d;
  logic [PARITY-1:0][SYM_W-1:0] r_q, r_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [SYM_W-1:0]             out_sym_q, out_sym_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_first_q, out_first_d;
  logic                         out_last_q, out_last_d;
  logic                         busy_q, busy_d;
  logic                         slot_free_c;
  logic [SYM_W-1:0]             fb_c;

  assign slot_free_c = !out_valid_q || out_ready;
  assign in_ready    = (state_q == ST_MSG) && slot_free_c && !rst;

  // Next-state, parity LFSR and output-slot loading.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    out_sym_d   = out_sym_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    fb_c        = '0;

    if (slot_free_c) begin
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      ST_MSG: begin
        if (in_valid && slot_free_c) begin
          out_sym_d   = in_sym;
          out_valid_d = 1'b1;
          out_first_d = (cnt_q == '0);
          fb_c        = in_sym ^ r_q[PARITY-1];
          r_d[0]      = gf_mul(GEN[3:0], fb_c);
          for (int i = 1; i < int'(PARITY); i++) begin
            r_d[i] = r_q[i-1] ^ gf_mul(GEN[4*i +: 4], fb_c);
          end
          if (cnt_q == CNT_W'(K - 1)) begin
            state_d = ST_PAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PAR: begin
        if (slot_free_c) begin
          out_sym_d   = r_q[PARITY-1];
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == CNT_W'(PARITY - 1));
          for (int i = int'(PARITY) - 1; i >= 1; i--) begin
            r_d[i] = r_q[i-1];
          end
          r_d[0] = '0;
          if (cnt_q == CNT_W'(PARITY - 1)) begin
            state_d = ST_MSG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_MSG;
    endcase

    busy_d = (state_d == ST_PAR) || (cnt_d != '0) || out_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_MSG;
      r_q         <= '0;
      cnt_q       <= '0;
      out_sym_q   <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      out_sym_q   <= out_sym_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign out_sym   = out_sym_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Scoreboard bench for rs_stream_encoder (defaults K=9, PARITY=6): directed words,
// back-to-back throughput, mid-codeword reset and a stalled/gapped random run.
module tb_rs_stream_encoder;

  localparam int K = 9;
  localparam int P = 6;
  localparam int N = K + P;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_sym;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sym;
  logic       out_first;
  logic       out_last;
  logic       busy;

  rs_stream_encoder #(.K(K), .PARITY(P)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .out_first(out_first), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sym;
    logic       first;
    logic       last;
  } exp_t;
  typedef logic [3:0] msg_t [K];

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         stall_en = 1'b0;
  logic [3:0] gb [P+1];
  int         first_acc_cyc;

  always @(posedge clk) cyc++;

  // Bench GF(16) multiply: full carry-less product, then reduce by x^4+x+1.
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (7'(a) << i);
    for (int i = 6; i >= 4; i--) if (p[i]) p = p ^ (7'(5'b10011) << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] gpow(input int e);
    logic [3:0] r;
    r = 4'h1;
    for (int i = 0; i < e; i++) r = gmul(r, 4'h2);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer, checks stall stability and syndromes.
  initial begin : monitor
    logic [3:0] cw [N];
    int         ncol;
    bit         prev_stall;
    int         prev_val;
    exp_t       e;
    ncol       = 0;
    prev_stall = 1'b0;
    prev_val   = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
        ncol       = 0;
      end else begin
        if (prev_stall)
          check("stall_hold", int'({out_valid, out_sym, out_first, out_last}), prev_val);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_symbol", int'(out_sym), 16);
          end else begin
            e = exp_q.pop_front();
            check("out_sym", int'(out_sym), int'(e.sym));
            check("first_last", int'({out_first, out_last}), int'({e.first, e.last}));
          end
          if (out_first) ncol = 0;
          if (ncol < N) cw[ncol] = out_sym;
          ncol++;
          if (out_last) begin
            check("codeword_len", ncol, N);
            for (int j = 1; j <= P; j++) begin
              logic [3:0] s;
              s = 4'h0;
              for (int k = 0; k < N; k++) s = gmul(s, gpow(j)) ^ cw[k];
              check("syndrome", int'(s), 0);
            end
            ncol = 0;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_val   = int'({out_valid, out_sym, out_first, out_last});
      end
    end
  end

  initial begin : ready_gen
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = stall_en ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Drives nsym symbols of m; pushes expected message symbols on accept and parity after the K-th.
  task automatic send_word(input msg_t m, input int gap_pct, input bit lat_chk, input int nsym);
    logic [3:0] w [N];
    logic [3:0] coef;
    int         i;
    int         guard;
    for (int k = 0; k < N; k++) w[k] = (k < K) ? m[k] : 4'h0;
    for (int k = 0; k < K; k++) begin
      coef = w[k];
      for (int j = 1; j <= P; j++) w[k+j] = w[k+j] ^ gmul(coef, gb[P-j]);
    end
    i     = 0;
    guard = 0;
    while (i < nsym) begin
      @(negedge clk);
      in_valid = (int'($urandom_range(99)) >= gap_pct);
      in_sym   = in_valid ? m[i] : 4'($urandom_range(15));
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back('{sym: m[i], first: (i == 0), last: 1'b0});
        if (i == K - 1)
          for (int k = 0; k < P; k++)
            exp_q.push_back('{sym: w[K+k], first: 1'b0, last: (k == P - 1)});
        if (i == 0) begin
          first_acc_cyc = cyc;
          if (lat_chk) begin
            @(posedge clk);
            #1;
            check("latency", int'({out_valid, out_first, out_sym}), int'({2'b11, m[0]}));
          end
        end
        i++;
      end
      guard++;
      if (guard > 2000) begin
        check("send_timeout", i, nsym);
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("idle_busy", int'({busy, out_valid}), 0);
  endtask

  initial begin : main
    msg_t m;
    int   c1, c2, c3;

    for (int j = 0; j <= P; j++) gb[j] = (j == 0) ? 4'h1 : 4'h0;
    for (int i = 1; i <= P; i++) begin
      for (int j = P; j >= 1; j--) gb[j] = gb[j-1] ^ gmul(gpow(i), gb[j]);
      gb[0] = gmul(gpow(i), gb[0]);
    end

    rst      = 1'b1;
    in_valid = 1'b0;
    in_sym   = 4'h0;
    @(negedge clk);
    #1;
    check("in_ready_in_reset", int'(in_ready), 0);
    @(posedge clk);
    #1;
    check("reset_outputs", int'({out_valid, out_sym, out_first, out_last, busy}), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", int'(in_ready), 1);

    // All-zero, single alpha^11 at c[10], then impulse at c[6]: back to back, no gaps.
    for (int i = 0; i < K; i++) m[i] = 4'h0;
    send_word(m, 0, 1'b1, K);
    c1 = first_acc_cyc;
    m[4] = 4'hE;
    send_word(m, 0, 1'b0, K);
    c2 = first_acc_cyc;
    m[4] = 4'h0;
    m[K-1] = 4'h1;
    send_word(m, 0, 1'b0, K);
    c3 = first_acc_cyc;
    check("throughput_w2", c2 - c1, N);
    check("throughput_w3", c3 - c2, N);
    wait_idle(100);

    // Reset after five message symbols, then a clean codeword.
    for (int i = 0; i < K; i++) m[i] = 4'($urandom_range(15));
    send_word(m, 0, 1'b0, 5);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_outputs", int'({out_valid, out_first, out_last, busy}), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < K; i++) m[i] = 4'($urandom_range(15));
    send_word(m, 0, 1'b0, K);
    wait_idle(100);

    // Random words with input gaps and 50% output back-pressure.
    stall_en = 1'b1;
    for (int w = 0; w < 200; w++) begin
      for (int i = 0; i < K; i++) m[i] = 4'($urandom_range(15));
      send_word(m, 30, 1'b0, K);
    end
    wait_idle(2000);
    stall_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
